// File: rtl/ds_inst_queue_if.sv
// ds_inst_queue_if: fetch-side and decode-side signals of the instruction queue.
//   master : pipeline side; drives in_valid/in_data/deq_num and observes the queue.
//   slave  : the queue; drives in_ready/out_valid/out_data/count/almost_full.
//   in_valid/in_data/in_ready  : one fetched entry per cycle, enqueued on valid & ready.
//   out_valid/out_data         : ISSUE_W decode slots, oldest entry in slot 0.
//   deq_num                    : number of slots decode consumes this cycle.
//   count/almost_full          : occupancy status.
interface ds_inst_queue_if #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DATA_W  = 96
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned DQ_W  = $clog2(ISSUE_W + 1);

  logic                      in_valid;
  logic [DATA_W-1:0]         in_data;
  logic                      in_ready;
  logic [ISSUE_W-1:0]        out_valid;
  logic [ISSUE_W*DATA_W-1:0] out_data;
  logic [DQ_W-1:0]           deq_num;
  logic [CNT_W-1:0]          count;
  logic                      almost_full;

  modport master (
    output in_valid, in_data, deq_num,
    input  in_ready, out_valid, out_data, count, almost_full
  );

  modport slave (
    input  in_valid, in_data, deq_num,
    output in_ready, out_valid, out_data, count, almost_full
  );
endinterface

// File: rtl/ds_inst_queue.sv
// ds_inst_queue: circular-buffer instruction queue between fetch and decode.
//   clk    : sole clock, all state on its rising edge.
//   resetn : asynchronous active-low reset; drops all entries.
//   flush  : synchronous pipeline flush; empties the queue next cycle.
//   q      : ds_inst_queue_if.slave (enqueue handshake, decode slots, status).
// Optional feature: define DS_QUEUE_BYPASS_EN to present an incoming entry in
// slot 0 in the same cycle when the queue is empty. Default build has no
// combinational path from q.in_* to q.out_*.
module ds_inst_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DATA_W  = 96
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  ds_inst_queue_if.slave    q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned DQ_W  = $clog2(ISSUE_W + 1);

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               almost_full_q, almost_full_d;
  logic [ISSUE_W-1:0] out_valid_q, out_valid_d;

  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               enq_c;
  logic               byp_c;
  logic               byp_take_c;
  logic [DQ_W-1:0]    deq_eff_c;
  logic [PTR_W-1:0]   rd_idx_c [ISSUE_W];

  // Bypass qualifies on in_ready so an entry is never both bypassed and re-offered.
  always_comb begin
`ifdef DS_QUEUE_BYPASS_EN
    byp_c = (count_q == '0) && q.in_valid && in_ready_q && !flush;
`else
    byp_c = 1'b0;
`endif
  end

  // Next-state: clamp dequeue to occupancy, enqueue only into free space.
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    in_ready_d    = in_ready_q;
    almost_full_d = almost_full_q;
    out_valid_d   = out_valid_q;

    deq_eff_c  = (CNT_W'(q.deq_num) > count_q) ? DQ_W'(count_q) : q.deq_num;
    byp_take_c = byp_c && (q.deq_num != '0);
    enq_c      = q.in_valid && in_ready_q && !flush && !byp_take_c;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_eff_c);
      tail_d  = tail_q + PTR_W'(enq_c);
      count_d = count_q + CNT_W'(enq_c) - CNT_W'(deq_eff_c);
    end

    // Status flops track the next occupancy so outputs come straight from flops.
    in_ready_d    = count_d < CNT_W'(DEPTH);
    almost_full_d = count_d >= CNT_W'(DEPTH - 1);
    for (int k = 0; k < int'(ISSUE_W); k++) begin
      out_valid_d[k] = count_d > CNT_W'(k);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b0;
      almost_full_q <= 1'b0;
      out_valid_q   <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      in_ready_q    <= in_ready_d;
      almost_full_q <= almost_full_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // Entry storage; contents are don't-care until marked valid, so no reset.
  always_ff @(posedge clk) begin
    if (enq_c) begin
      mem_q[tail_q] <= q.in_data;
    end
  end

  // Slot k reads entry head+k, wrapping naturally in PTR_W bits.
  always_comb begin
    for (int k = 0; k < int'(ISSUE_W); k++) begin
      rd_idx_c[k] = head_q + PTR_W'(k);
    end
  end

  // Decode slot outputs; only slot 0 can be bypassed.
  always_comb begin
    q.out_valid    = out_valid_q;
    q.out_valid[0] = out_valid_q[0] | byp_c;
    for (int k = 0; k < int'(ISSUE_W); k++) begin
      q.out_data[k*DATA_W +: DATA_W] = mem_q[rd_idx_c[k]];
    end
    if (byp_c) begin
      q.out_data[0 +: DATA_W] = q.in_data;
    end
  end

  assign q.in_ready    = in_ready_q;
  assign q.count       = count_q;
  assign q.almost_full = almost_full_q;

endmodule

// File: doc/ds_inst_queue.md
DS_INST_QUEUE -- requirements
Module: ds_inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries; power of two, at least 2, at least ISSUE_W.
REQ-002 SHALL have parameter ISSUE_W, default 2, number of decode slots presented per cycle.
REQ-003 SHALL have parameter DATA_W, default 96, width of one fetched entry {pc, inst, exception fields}.
REQ-004 SHALL have port clk, input, 1, sole clock; one clock, all state on its rising edge.
REQ-005 SHALL have port resetn, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port flush, input, 1, pipeline flush (ex/eret/tlb/cache/branch redirect), synchronous.
REQ-007 SHALL have port in_valid, input, 1, fetch entry offered.
REQ-008 SHALL have port in_data, input, DATA_W, fetch entry payload.
REQ-009 SHALL have port in_ready, output, 1, queue accepts an entry this cycle (allowin).
REQ-010 SHALL have port out_valid, output, ISSUE_W, bit k set when decode slot k holds a valid entry.
REQ-011 SHALL have port out_data, output, ISSUE_W*DATA_W, slot k in bits [k*DATA_W +: DATA_W], oldest in slot 0.
REQ-012 SHALL have port deq_num, input, clog2(ISSUE_W+1), number of slots decode consumes this cycle.
REQ-013 SHALL have port count, output, clog2(DEPTH+1), current occupancy.
REQ-014 SHALL have port almost_full, output, 1, count >= DEPTH-1.

Function
REQ-015 Storage SHALL be a circular buffer with head and tail pointers of clog2(DEPTH) bits, both wrapping modulo DEPTH.
REQ-016 in_ready SHALL equal (count < DEPTH), from registered state only, with no dependence on deq_num.
REQ-017 Enqueue SHALL occur when in_valid && in_ready && !flush: write at tail, tail+1.
REQ-018 out_valid[k] SHALL equal (count > k); out_data slot k SHALL read entry (head+k) mod DEPTH.
REQ-019 Effective dequeue SHALL be min(deq_num, count), so over-requests are clamped and never underflow.
REQ-020 Next count SHALL be count + enq - effective dequeue, with enqueue and dequeue allowed in the same cycle.
REQ-021 When count == DEPTH, no enqueue SHALL occur even with a simultaneous dequeue; the freed space is usable next cycle.
REQ-022 Order SHALL be strict FIFO, and dequeued entries SHALL always be a contiguous prefix from slot 0.
REQ-023 flush SHALL take priority over everything: next cycle count=0, head=tail=0, and any same-cycle enqueue and dequeue are discarded.
REQ-024 Without bypass, minimum latency from enqueue to out_valid[0] SHALL be 1 cycle.

Reset
REQ-025 While resetn=0, the block SHALL hold count=0, head=tail=0, out_valid=0, in_ready=0 and almost_full=0, asynchronously.
REQ-026 Entry storage SHALL NOT need reset; out_data content is don't-care while out_valid is 0.
REQ-027 Reset asserted mid-operation SHALL drop all entries; after deassertion, in_ready SHALL rise in the first cycle.

Configuration
REQ-028 Macro DS_QUEUE_BYPASS_EN SHALL control the bypass path.
REQ-029 With DS_QUEUE_BYPASS_EN defined: when count==0 and in_valid && !flush, out_valid[0]=1 and slot 0 SHALL carry in_data in the same cycle.
REQ-030 With DS_QUEUE_BYPASS_EN defined: if that bypassed entry is dequeued (deq_num>=1), it SHALL NOT be written and count SHALL stay 0.
REQ-031 With DS_QUEUE_BYPASS_EN defined: slots above 0 SHALL never be bypassed.
REQ-032 Without DS_QUEUE_BYPASS_EN: no combinational path SHALL exist from in_* to out_*, and REQ-024 latency applies.

Verification
REQ-033 Reset then enqueue A,B,C on consecutive cycles with deq_num=0 -> count 1,2,3; slot0=A, slot1=B; almost_full=0.
REQ-034 DEPTH=8: fill 8 entries -> in_ready=0 and almost_full=1; deq_num=2 while in_valid=1 -> count=6, no write, in_ready=1 next cycle.
REQ-035 count=1 with deq_num=2 -> effective dequeue 1, count=0, out_valid=00, no pointer corruption.
REQ-036 count=5 with flush, in_valid=1 and deq_num=1 in the same cycle -> next cycle count=0, out_valid=0; the following enqueue appears in slot 0.
REQ-037 Wrap-around: 20 enqueue/dequeue pairs of 1 at count=3 -> data order preserved across the pointer wrap, with each entry at slot 0 exactly three cycles after it is enqueued.
REQ-038 Bypass enabled, empty queue, in_valid=1 with deq_num=1 -> out_valid[0]=1 with in_data in that cycle and count stays 0; bypass disabled, same stimulus -> out_valid=0 that cycle and count=1 next cycle.
